// File: rtl/vga_axil_pkg.sv
// Shared AXI4-Lite types and FSM state encodings for the VGA control register file.
// The optional byte-strobe feature is selected with the VGA_AXIL_WSTRB_EN macro.
package vga_axil_pkg;

  localparam int AXIL_ADDR_W = 32;
  localparam int AXIL_DATA_W = 32;
  localparam int AXIL_STRB_W = AXIL_DATA_W / 8;

  typedef logic [AXIL_ADDR_W-1:0] axil_addr_t;
  typedef logic [AXIL_DATA_W-1:0] axil_data_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } axil_resp_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  // Expand byte strobes into a per-bit write mask.
  function automatic axil_data_t strb_to_mask(input logic [AXIL_STRB_W-1:0] strb);
    axil_data_t mask;
    mask = '0;
    for (int b = 0; b < AXIL_STRB_W; b++) begin
      mask[b*8 +: 8] = {8{strb[b]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/vga_axil_addr_dec.sv
// Byte address -> register index decode with range check.
// Address bits below ADDR_LSB are ignored; any set bit above the index field marks
// the access as out of range.
module vga_axil_addr_dec
  import vga_axil_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int ADDR_LSB = 2,
  parameter int IDXW     = $clog2(NUM_REGS)
) (
  input  logic [AXIL_ADDR_W-1:0] addr,
  output logic [IDXW-1:0]        idx,
  output logic                   in_range
);

  localparam int HI_SHIFT = ADDR_LSB + IDXW;

  assign idx      = addr[ADDR_LSB +: IDXW];
  assign in_range = ((addr >> HI_SHIFT) == '0);

endmodule

// File: rtl/vga_axil_regfile.sv
// AXI4-Lite responder holding NUM_REGS 32-bit VGA control registers.
// Independent write and read FSMs, one outstanding transaction each.
// Define VGA_AXIL_WSTRB_EN to honour wstrb byte enables; otherwise full words are written.
module vga_axil_regfile
  import vga_axil_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int ADDR_LSB = 2
) (
  input  logic                            clk,
  input  logic                            arst_n,
  input  logic [AXIL_ADDR_W-1:0]          awaddr,
  input  logic                            awvalid,
  output logic                            awready,
  input  logic [AXIL_DATA_W-1:0]          wdata,
  input  logic [AXIL_STRB_W-1:0]          wstrb,
  input  logic                            wvalid,
  output logic                            wready,
  output logic [1:0]                      bresp,
  output logic                            bvalid,
  input  logic                            bready,
  input  logic [AXIL_ADDR_W-1:0]          araddr,
  input  logic                            arvalid,
  output logic                            arready,
  output logic [AXIL_DATA_W-1:0]          rdata,
  output logic [1:0]                      rresp,
  output logic                            rvalid,
  input  logic                            rready,
  output logic [NUM_REGS*AXIL_DATA_W-1:0] regs_o
);

  localparam int IDXW = $clog2(NUM_REGS);

  // Write-side state
  wr_state_t              wr_state_q, wr_state_d;
  logic [AXIL_ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [AXIL_DATA_W-1:0] wdata_q, wdata_d;
  axil_resp_t             bresp_q, bresp_d;
  logic                   wr_commit;

  // Read-side state
  rd_state_t              rd_state_q, rd_state_d;
  logic [AXIL_DATA_W-1:0] rdata_q, rdata_d;
  axil_resp_t             rresp_q, rresp_d;

  // Register storage viewed as a packed array, reg k at [k]
  logic [NUM_REGS-1:0][AXIL_DATA_W-1:0] regs_flat;

  logic aw_hs, w_hs, ar_hs;
  logic [AXIL_ADDR_W-1:0] wr_addr;
  logic [AXIL_DATA_W-1:0] wr_data;
  logic [AXIL_DATA_W-1:0] wr_mask;
  logic [IDXW-1:0]        wr_idx, rd_idx;
  logic                   wr_in_range, rd_in_range;

  assign awready = (wr_state_q == W_IDLE) || (wr_state_q == W_HAVE_W);
  assign wready  = (wr_state_q == W_IDLE) || (wr_state_q == W_HAVE_AW);
  assign bvalid  = (wr_state_q == W_RESP);
  assign bresp   = bresp_q;
  assign arready = (rd_state_q == R_IDLE);
  assign rvalid  = (rd_state_q == R_DATA);
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign regs_o  = regs_flat;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign ar_hs = arvalid && arready;

  // A beat arriving on the commit edge is used directly; an earlier one comes from its holding flop.
  assign wr_addr = aw_hs ? awaddr : awaddr_q;
  assign wr_data = w_hs ? wdata : wdata_q;

`ifdef VGA_AXIL_WSTRB_EN
  logic [AXIL_STRB_W-1:0] wstrb_q, wstrb_d;

  // Hold the write strobes alongside the write data.
  always_comb begin
    wstrb_d = wstrb_q;
    if (w_hs) wstrb_d = wstrb;
  end

  // Strobe holding register.
  always_ff @(posedge clk) begin
    if (!arst_n) wstrb_q <= '0;
    else         wstrb_q <= wstrb_d;
  end

  assign wr_mask = strb_to_mask(w_hs ? wstrb : wstrb_q);
`else
  logic unused_wstrb;
  assign unused_wstrb = ^wstrb;
  assign wr_mask      = '1;
`endif

  vga_axil_addr_dec #(
    .NUM_REGS (NUM_REGS),
    .ADDR_LSB (ADDR_LSB),
    .IDXW     (IDXW)
  ) u_wr_dec (
    .addr     (wr_addr),
    .idx      (wr_idx),
    .in_range (wr_in_range)
  );

  vga_axil_addr_dec #(
    .NUM_REGS (NUM_REGS),
    .ADDR_LSB (ADDR_LSB),
    .IDXW     (IDXW)
  ) u_rd_dec (
    .addr     (araddr),
    .idx      (rd_idx),
    .in_range (rd_in_range)
  );

  // Write FSM next state, beat capture and response generation.
  always_comb begin
    wr_state_d = wr_state_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    bresp_d    = bresp_q;
    wr_commit  = 1'b0;
    if (aw_hs) awaddr_d = awaddr;
    if (w_hs)  wdata_d  = wdata;
    case (wr_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) wr_state_d = W_RESP;
        else if (aw_hs)    wr_state_d = W_HAVE_AW;
        else if (w_hs)     wr_state_d = W_HAVE_W;
      end
      W_HAVE_AW: if (w_hs)   wr_state_d = W_RESP;
      W_HAVE_W:  if (aw_hs)  wr_state_d = W_RESP;
      W_RESP:    if (bready) wr_state_d = W_IDLE;
      default:   wr_state_d = W_IDLE;
    endcase
    // The edge that enters W_RESP commits the register and latches the response.
    if ((wr_state_q != W_RESP) && (wr_state_d == W_RESP)) begin
      wr_commit = 1'b1;
      bresp_d   = wr_in_range ? OKAY : SLVERR;
    end
  end

  // Write FSM registers.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      wr_state_q <= W_IDLE;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      bresp_q    <= OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      bresp_q    <= bresp_d;
    end
  end

  // One flop word per register; only an in-range write commit can change it.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    logic [AXIL_DATA_W-1:0] reg_q, reg_d;

    // Merge the enabled bytes of the write data into this register on commit.
    always_comb begin
      reg_d = reg_q;
      if (wr_commit && wr_in_range && (wr_idx == IDXW'(gi))) begin
        reg_d = (reg_q & ~wr_mask) | (wr_data & wr_mask);
      end
    end

    // Register word storage.
    always_ff @(posedge clk) begin
      if (!arst_n) reg_q <= '0;
      else         reg_q <= reg_d;
    end

    assign regs_flat[gi] = reg_q;
  end

  // Read FSM next state; data is sampled from the pre-commit register values.
  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          rd_state_d = R_DATA;
          rdata_d    = rd_in_range ? regs_flat[rd_idx] : '0;
          rresp_d    = rd_in_range ? OKAY : SLVERR;
        end
      end
      R_DATA:  if (rready) rd_state_d = R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Read FSM registers.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      rd_state_q <= R_IDLE;
      rdata_q    <= '0;
      rresp_q    <= OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

endmodule
